// File: rtl/hfused_frame_store.sv
// Frame store for iterative fusion: streams the previous fused frame alongside new/ref pixels
// and writes fused results back FUSION_LATENCY cycles later; emits the final frame on the last image.
module hfused_frame_store #(
  parameter int FUSEDIMAGE_DATA_WIDTH = 8,
  parameter int IM_LEN                = 520,
  parameter int IM_WID                = 520,
  parameter int LOG2_NO_OF_IMAGES     = 4,
  parameter int FUSION_LATENCY        = 20
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 pix_valid,
  input  logic [7:0]                           hnew_in,
  input  logic [7:0]                           href_in,
  output logic [7:0]                           hnew_out,
  output logic [7:0]                           href_out,
  output logic [FUSEDIMAGE_DATA_WIDTH-1:0]     hfuse_out,
  output logic                                 stream_valid,
  input  logic [FUSEDIMAGE_DATA_WIDTH-1:0]     hfused_in,
  output logic [FUSEDIMAGE_DATA_WIDTH-1:0]     fused_out,
  output logic                                 fused_valid,
  output logic [LOG2_NO_OF_IMAGES-1:0]         img_idx,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_gap
);
  localparam int W  = FUSEDIMAGE_DATA_WIDTH;
  localparam int N  = IM_LEN * IM_WID;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int L  = FUSION_LATENCY;
  localparam int CW = $clog2(L + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_FUSE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  mem [N];
  logic [AW-1:0] rd_addr, wr_addr;
  logic [L-1:0]  wr_line;
  logic [CW-1:0] drain_cnt;
  logic [W-1:0]  rd_q;
  logic          stream_fuse, first_q, first_frame, wr_done;
  logic          reading, take, last_rd, wr_vld, wr_last, last_img, drain_ok;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;

  assign reading  = (state == S_FIRST) || (state == S_FUSE);
  assign take     = reading && pix_valid;
  assign last_rd  = take && (rd_addr == LAST_ADDR);
  assign wr_vld   = wr_line[L-1];
  assign wr_last  = wr_vld && (wr_addr == LAST_ADDR);
  assign last_img = (img_idx == {LOG2_NO_OF_IMAGES{1'b1}});
  // A first frame has no feedback writes; otherwise wait until the write pointer wraps.
  assign drain_ok = (drain_cnt >= CW'(L - 1)) && (first_frame || wr_done || wr_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = (img_idx == '0) ? S_FIRST : S_FUSE;
      S_FIRST,
      S_FUSE:  if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_ok) state_nxt = last_img ? S_DONE : S_IDLE;
      S_DONE:  if (frame_start) state_nxt = S_FIRST;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_FIRST) || (state == S_FUSE) || (state == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hnew_out     <= '0;
      href_out     <= '0;
      stream_valid <= 1'b0;
      stream_fuse  <= 1'b0;
      first_q      <= 1'b0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      wr_line      <= '0;
      wr_done      <= 1'b0;
      first_frame  <= 1'b0;
      drain_cnt    <= '0;
      img_idx      <= '0;
      done         <= 1'b0;
      err_gap      <= 1'b0;
    end else begin
      hnew_out     <= hnew_in;
      href_out     <= href_in;
      stream_valid <= take;
      stream_fuse  <= take && (state == S_FUSE);
      first_q      <= (state == S_FIRST);
      wr_line      <= (wr_line << 1) | L'(stream_fuse);
      if (take)   rd_addr <= last_rd ? '0 : rd_addr + AW'(1);
      if (wr_vld) wr_addr <= wr_last ? '0 : wr_addr + AW'(1);
      if ((state == S_IDLE) || (state == S_DONE)) begin
        wr_done <= 1'b0;
        if (frame_start) first_frame <= (state_nxt == S_FIRST);
      end else if (wr_last) begin
        wr_done <= 1'b1;
      end
      if (state == S_DRAIN) begin
        if (drain_cnt != CW'(L)) drain_cnt <= drain_cnt + CW'(1);
      end else begin
        drain_cnt <= '0;
      end
      if ((state == S_DRAIN) && drain_ok && !last_img) img_idx <= img_idx + LOG2_NO_OF_IMAGES'(1);
      else if ((state == S_DONE) && frame_start)       img_idx <= '0;
      done <= (state == S_DRAIN) && drain_ok;
      // Stalls before the first pixel of a frame are allowed; a stall mid-frame is a gap.
      if (reading && !pix_valid && (rd_addr != '0)) err_gap <= 1'b1;
    end
  end

  assign mem_we    = ((state == S_FIRST) && take) || wr_vld;
  assign mem_waddr = wr_vld ? wr_addr : rd_addr;
  assign mem_wdata = wr_vld ? hfused_in : W'(hnew_in);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rd_q <= '0;
    else if (take) rd_q <= mem[rd_addr];
  end

  assign hfuse_out   = first_q ? W'(hnew_out) : rd_q;
  assign fused_valid = wr_vld && last_img;
  assign fused_out   = fused_valid ? hfused_in : '0;
endmodule

// File: tb/tb_hfused_frame_store.sv
// Scoreboard bench for hfused_frame_store on a 4x4 frame, two images per sequence, latency 20.
module tb_hfused_frame_store;
  localparam int NPIX = 16;
  localparam int LAT  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] hnew_in = '0, href_in = '0;
  logic [7:0] hnew_out, href_out, hfuse_out, fused_out;
  logic [7:0] hfused_in = '0;
  logic       stream_valid, fused_valid, busy, done, err_gap;
  logic [0:0] img_idx;

  hfused_frame_store #(
    .FUSEDIMAGE_DATA_WIDTH(8), .IM_LEN(4), .IM_WID(4),
    .LOG2_NO_OF_IMAGES(1), .FUSION_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .hnew_in(hnew_in), .href_in(href_in), .hnew_out(hnew_out), .href_out(href_out),
    .hfuse_out(hfuse_out), .stream_valid(stream_valid), .hfused_in(hfused_in),
    .fused_out(fused_out), .fused_valid(fused_valid), .img_idx(img_idx),
    .busy(busy), .done(done), .err_gap(err_gap)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_done = 0;
  int q_hnew[$], q_href[$], q_hfuse[$], q_fused[$];
  logic [7:0] dl [0:LAT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model fusion stage: returns hfuse+1 exactly LAT cycles after each streamed pixel.
  always @(posedge clk) begin
    #1;
    for (int i = LAT; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = stream_valid ? hfuse_out + 8'd1 : 8'd0;
    hfused_in = dl[LAT];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (stream_valid) begin
        if (q_hfuse.size() == 0) check("stream_extra", 1, 0);
        else begin
          check("hnew_out", hnew_out, q_hnew.pop_front());
          check("href_out", href_out, q_href.pop_front());
          check("hfuse_out", hfuse_out, q_hfuse.pop_front());
        end
      end
      if (fused_valid) begin
        if (q_fused.size() == 0) check("fused_extra", 1, 0);
        else check("fused_out", fused_out, q_fused.pop_front());
      end
      if (done) n_done++;
    end
  end

  task automatic drive_frame(input int base, input int img, input int fbase,
                             input int gap_after, input int stop_at, input bit fs_busy);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int a = 0; a < NPIX; a++) begin
      if (a == stop_at) break;
      pix_valid = 1'b1;
      hnew_in   = 8'(base + a);
      href_in   = 8'(a * 3 + 1);
      frame_start = fs_busy && (a == 3);
      q_hnew.push_back((base + a) & 255);
      q_href.push_back((a * 3 + 1) & 255);
      q_hfuse.push_back(((img == 0) ? base + a : fbase + a) & 255);
      if (img == 1) q_fused.push_back((fbase + a + 1) & 255);
      if (fs_busy && a == 3) begin
        check("fs_busy_busy", busy, 1);
        check("fs_busy_idx", img_idx, 0);
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (a == gap_after) begin
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    check(tag, got, 1);
  endtask

  initial begin
    for (int i = 0; i <= LAT; i++) dl[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", img_idx, 0);
    check("rst_svalid", stream_valid, 0);
    check("rst_fvalid", fused_valid, 0);
    check("rst_err", err_gap, 0);
    check("rst_hfuse", hfuse_out, 0);
    check("rst_fused", fused_out, 0);

    // Image 0 (FIRST), with a frame_start while busy.
    drive_frame(0, 0, 0, -1, -1, 1'b1);
    wait_done("done_img0", 100);
    check("img0_idx", img_idx, 1);
    check("img0_busy", busy, 0);
    check("img0_err", err_gap, 0);

    // Image 1 (FUSE, last image) with a 3-cycle gap after pixel 5.
    drive_frame(100, 1, 0, 5, -1, 1'b0);
    check("gap_err", err_gap, 1);
    wait_done("done_img1", 100);
    check("img1_busy", busy, 0);
    check("img1_idx", img_idx, 1);

    // From DONE, a new sequence restarts at image 0.
    drive_frame(50, 0, 0, -1, -1, 1'b0);
    wait_done("done_img0b", 100);
    check("img0b_idx", img_idx, 1);
    check("err_sticky", err_gap, 1);

    // Reset at pixel 8 of image 1.
    drive_frame(7, 1, 50, -1, 8, 1'b0);
    rst = 1'b1;
    q_hnew.delete(); q_href.delete(); q_hfuse.delete(); q_fused.delete();
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_idx", img_idx, 0);
    check("mrst_err", err_gap, 0);
    check("mrst_svalid", stream_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mrst_idle", busy, 0);

    // After reset the next frame must be FIRST, then a full fused image.
    drive_frame(200, 0, 0, -1, -1, 1'b0);
    wait_done("done_img0c", 100);
    drive_frame(30, 1, 200, -1, -1, 1'b0);
    wait_done("done_img1c", 100);
    repeat (5) @(negedge clk);

    check("q_hfuse_empty", q_hfuse.size(), 0);
    check("q_fused_empty", q_fused.size(), 0);
    check("done_count", n_done, 5);
    check("final_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
